// File: rtl/fifo_wr_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing the async FIFO write port among NREQ wclk-domain requesters.
// A grant covers one burst, ended by req_last or MAX_BURST beats; beats stall on wfull.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DSIZE-1:0]     req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      wfull,
  output logic                      winc,
  output logic [DSIZE-1:0]          wdata,
  output logic [$clog2(NREQ)-1:0]   gnt_id,
  output logic                      gnt_vld,
  output logic [CNT_W-1:0]          wr_count
);

  localparam int unsigned ID_W = $clog2(NREQ);
  localparam int unsigned BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic              gnt_vld_q, gnt_vld_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;

  logic              beat_c;
  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   cand;

  // Beat-side outputs depend only on registered grant, req_valid, wfull and the granted data lane.
  always_comb begin
    beat_c    = (state_q == BURST) && req_valid[gnt_id_q] && !wfull;
    winc      = beat_c;
    req_ready = '0;
    wdata     = '0;
    if (beat_c) begin
      req_ready[gnt_id_q] = 1'b1;
    end
    if (state_q == BURST) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (gnt_id_q == ID_W'(i)) begin
          wdata = req_data[i*DSIZE +: DSIZE];
        end
      end
    end
  end

  // Circular search starting just above the last owner.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = rr_ptr_q + ID_W'(k);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    gnt_vld_d  = gnt_vld_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    wr_count_d = wr_count_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_id_d   = pick_id;
          gnt_vld_d  = 1'b1;
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (beat_c) begin
          wr_count_d = wr_count_q + CNT_W'(1);
          if (req_last[gnt_id_q] || (beat_cnt_q == BC_LAST)) begin
            rr_ptr_d  = gnt_id_q;
            gnt_vld_d = 1'b0;
            state_d   = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + BC_W'(1);
          end
        end
      end
      default: begin
        state_d   = IDLE;
        gnt_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      gnt_id_q   <= '0;
      gnt_vld_q  <= 1'b0;
      rr_ptr_q   <= ID_W'(NREQ - 1);
      beat_cnt_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      gnt_vld_q  <= gnt_vld_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign gnt_id   = gnt_id_q;
  assign gnt_vld  = gnt_vld_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for fifo_wr_arbiter: a transaction-level round-robin model predicts
// the ordered beat stream; a monitor checks each cycle's outputs against it.
module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 4;
  localparam int CNT_W     = 16;
  localparam int MAXC      = 2000;

  typedef struct packed {
    logic [DSIZE-1:0] data;
    logic             last;
  } beat_t;

  typedef struct packed {
    logic [1:0]       id;
    logic [DSIZE-1:0] data;
    logic             rel;
  } exp_t;

  logic                  wclk = 1'b0;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [1:0]            gnt_id;
  logic                  gnt_vld;
  logic [CNT_W-1:0]      wr_count;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .wfull(wfull), .winc(winc),
    .wdata(wdata), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .wr_count(wr_count)
  );

  always #5 wclk = ~wclk;

  beat_t src_q[NREQ][$];
  exp_t  exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    model_ptr;
  int    exp_count;
  bit    hung = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input int id, input logic [DSIZE-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    src_q[id].push_back(b);
  endtask

  // Round robin over requesters with pending beats; each grant takes beats until last or MAX_BURST.
  task automatic model_load();
    int head[NREQ];
    int n, id, c;
    bit any;
    beat_t b;
    exp_t e;
    for (int i = 0; i < NREQ; i++) head[i] = 0;
    forever begin
      any = 0;
      id = 0;
      for (int k = 1; k <= NREQ; k++) begin
        c = (model_ptr + k) % NREQ;
        if (!any && head[c] < src_q[c].size()) begin
          any = 1;
          id = c;
        end
      end
      if (!any) break;
      n = 0;
      while (head[id] < src_q[id].size()) begin
        b = src_q[id][head[id]];
        head[id]++;
        n++;
        e.id = 2'(id);
        e.data = b.data;
        e.rel = b.last || (n == MAX_BURST);
        exp_q.push_back(e);
        if (e.rel) break;
      end
      model_ptr = id;
    end
  endtask

  task automatic drive_idle();
    req_valid = '0;
    req_last = '0;
    wfull = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge wclk);
    drive_idle();
    #4;
  endtask

  task automatic clear_src();
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
  endtask

  task automatic run_phase(input int stall_at, input int stall_len, input bit rnd_full,
                           input bit gaps, input int abort_at, output int cycles);
    int acc, scnt;
    bit empty;
    acc = 0;
    scnt = 0;
    cycles = 0;
    forever begin
      @(negedge wclk);
      cycles++;
      if (stall_at >= 0 && acc >= stall_at && scnt < stall_len) begin
        wfull = 1'b1;
        scnt++;
      end else begin
        wfull = rnd_full ? ($urandom_range(3) == 0) : 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i] = !(gaps && gnt_vld && (int'(gnt_id) == i) && ($urandom_range(3) == 0));
          req_data[i*DSIZE +: DSIZE] = src_q[i][0].data;
          req_last[i] = src_q[i][0].last;
        end else begin
          req_valid[i] = 1'b0;
          req_data[i*DSIZE +: DSIZE] = DSIZE'($urandom);
          req_last[i] = 1'($urandom_range(1));
        end
      end
      if (abort_at >= 0 && acc == abort_at) begin
        #2;
        chk("abort_pre_winc", 32'(winc), 32'd1);
        wrst_n = 1'b0;
        #1;
        chk("abort_winc", 32'(winc), 32'd0);
        chk("abort_gnt_vld", 32'(gnt_vld), 32'd0);
        chk("abort_wr_count", 32'(wr_count), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        clear_src();
        return;
      end
      #4;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && src_q[i].size() > 0) begin
          void'(src_q[i].pop_front());
          acc++;
        end
      end
      empty = 1;
      for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) empty = 0;
      if (empty) break;
      if (cycles >= MAXC) begin
        total++;
        bad++;
        $display("FAIL timeout cycles=%0d limit=%0d", cycles, MAXC);
        hung = 1;
        clear_src();
        break;
      end
    end
  endtask

  task automatic summary_and_finish();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Monitor: samples late in each cycle and checks against the scoreboard queue.
  bit       prev_rel, prev_gnt, prev_beat, cur_rel;
  logic [1:0] prev_id;
  always @(negedge wclk) begin
    exp_t e;
    logic [NREQ-1:0] oh;
    #4;
    if (!wrst_n) begin
      exp_q.delete();
      exp_count = 0;
      prev_rel = 0;
      prev_gnt = 0;
      prev_beat = 0;
      prev_id = '0;
    end else begin
      chk("wr_count", 32'(wr_count), 32'(CNT_W'(exp_count)));
      if (prev_rel) begin
        chk("bubble_gnt_vld", 32'(gnt_vld), 32'd0);
        chk("bubble_winc", 32'(winc), 32'd0);
      end
      if (prev_gnt && !prev_beat) begin
        chk("hold_gnt_vld", 32'(gnt_vld), 32'd1);
        chk("hold_gnt_id", 32'(gnt_id), 32'(prev_id));
      end
      if (wfull) chk("stall_winc", 32'(winc), 32'd0);
      if (!gnt_vld) begin
        chk("idle_winc", 32'(winc), 32'd0);
        chk("idle_wdata", 32'(wdata), 32'd0);
      end
      cur_rel = 0;
      if (winc) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat id=%0d data=%0h exp=none", gnt_id, wdata);
        end else begin
          e = exp_q.pop_front();
          oh = '0;
          oh[e.id] = 1'b1;
          chk("beat_id", 32'(gnt_id), 32'(e.id));
          chk("beat_data", 32'(wdata), 32'(e.data));
          chk("beat_ready", 32'(req_ready), 32'(oh));
          cur_rel = e.rel;
          exp_count++;
        end
      end else begin
        chk("ready_zero", 32'(req_ready), 32'd0);
      end
      prev_rel = cur_rel;
      prev_gnt = gnt_vld;
      prev_beat = winc;
      prev_id = gnt_id;
    end
  end

  initial begin
    int cyc, n;
    logic l;
    wrst_n = 1'b0;
    req_data = '0;
    drive_idle();
    model_ptr = NREQ - 1;
    exp_count = 0;
    #3;
    chk("rst_gnt_vld", 32'(gnt_vld), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_winc", 32'(winc), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Round robin from reset: two 2-beat bursts each from requesters 0 and 1.
    for (int b = 0; b < 4; b++) begin
      push_beat(0, DSIZE'(8'h10 + b), 1'(b % 2));
      push_beat(1, DSIZE'(8'h20 + b), 1'(b % 2));
    end
    model_load();
    run_phase(-1, 0, 0, 0, -1, cyc);
    if (hung) summary_and_finish();
    chk("rr_cycles", 32'(cyc), 32'd12);
    idle_cycle();
    chk("rr_count", 32'(wr_count), 32'd8);

    // Single burst on requester 2.
    push_beat(2, 8'hA1, 1'b0);
    push_beat(2, 8'hA2, 1'b0);
    push_beat(2, 8'hA3, 1'b1);
    model_load();
    run_phase(-1, 0, 0, 0, -1, cyc);
    if (hung) summary_and_finish();
    chk("single_cycles", 32'(cyc), 32'd4);
    idle_cycle();
    chk("single_count", 32'(wr_count), 32'd11);

    // Truncation: requester 3 streams 6 beats, requester 1 pending.
    for (int b = 0; b < 6; b++) push_beat(3, DSIZE'(8'h30 + b), 1'(b == 5));
    push_beat(1, 8'h41, 1'b0);
    push_beat(1, 8'h42, 1'b1);
    model_load();
    run_phase(-1, 0, 0, 0, -1, cyc);
    if (hung) summary_and_finish();
    chk("trunc_cycles", 32'(cyc), 32'd11);
    idle_cycle();

    // Full stall for 5 cycles after beat 1 of a 4-beat burst.
    for (int b = 0; b < 4; b++) push_beat(1, DSIZE'(8'h50 + b), 1'(b == 3));
    model_load();
    run_phase(1, 5, 0, 0, -1, cyc);
    if (hung) summary_and_finish();
    chk("stall_cycles", 32'(cyc), 32'd10);
    idle_cycle();

    // Reset during beat 2 of a burst on requester 2.
    for (int b = 0; b < 4; b++) push_beat(2, DSIZE'(8'h60 + b), 1'(b == 3));
    model_load();
    run_phase(-1, 0, 0, 0, 1, cyc);
    drive_idle();
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
    model_ptr = NREQ - 1;

    // Fairness: all four requesters, 1-beat bursts, 40 cycles.
    for (int b = 0; b < 5; b++)
      for (int i = 0; i < NREQ; i++) push_beat(i, DSIZE'(8'h80 + b * 4 + i), 1'b1);
    model_load();
    run_phase(-1, 0, 0, 0, -1, cyc);
    if (hung) summary_and_finish();
    chk("fair_cycles", 32'(cyc), 32'd40);
    idle_cycle();

    // Random phases with random wfull and owner valid gaps.
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < NREQ; i++) begin
        n = $urandom_range(7);
        for (int b = 0; b < n; b++) begin
          l = (b == n - 1) ? 1'b1 : ($urandom_range(2) == 0);
          push_beat(i, DSIZE'($urandom), l);
        end
      end
      model_load();
      run_phase(-1, 0, 1, 1, -1, cyc);
      if (hung) summary_and_finish();
      if ($urandom_range(1) == 1) idle_cycle();
    end

    idle_cycle();
    idle_cycle();
    chk("drain", 32'(exp_q.size()), 32'd0);
    summary_and_finish();
  end

endmodule
